// File: rtl/spi_slave_shift_if.sv
// Parallel tx-load / rx-deliver port plus SPI pad signals of spi_slave_shift.
// Optional status signals appear only when SPI_SLAVE_STATUS_EN is defined.
interface spi_slave_shift_if #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 5
) ();
    logic [LEN_W-1:0]   i_len;
    logic               i_lsb;
    logic               i_rx_negedge;
    logic               i_tx_negedge;
    logic [MAX_LEN-1:0] i_tx_data;
    logic               i_tx_valid;
    logic               o_tx_ready;
    logic [MAX_LEN-1:0] o_rx_data;
    logic               o_rx_valid;
    logic               o_busy;
    logic               i_pad_sclk;
    logic               i_pad_ss;
    logic               i_pad_mosi;
    logic               o_pad_miso;
    logic               o_pad_miso_oe;
`ifdef SPI_SLAVE_STATUS_EN
    logic               i_status_clr;
    logic               o_underrun;
    logic               o_abort;
`endif

    modport slave (
        input  i_len, i_lsb, i_rx_negedge, i_tx_negedge, i_tx_data, i_tx_valid,
        input  i_pad_sclk, i_pad_ss, i_pad_mosi,
        output o_tx_ready, o_rx_data, o_rx_valid, o_busy, o_pad_miso, o_pad_miso_oe
`ifdef SPI_SLAVE_STATUS_EN
        , input i_status_clr, output o_underrun, o_abort
`endif
    );

    modport master (
        output i_len, i_lsb, i_rx_negedge, i_tx_negedge, i_tx_data, i_tx_valid,
        output i_pad_sclk, i_pad_ss, i_pad_mosi,
        input  o_tx_ready, o_rx_data, o_rx_valid, o_busy, o_pad_miso, o_pad_miso_oe
`ifdef SPI_SLAVE_STATUS_EN
        , output i_status_clr, input o_underrun, o_abort
`endif
    );
endinterface

// File: rtl/spi_slave_shift.sv
// SPI responder, pads oversampled in i_clk; SPI_SLAVE_STATUS_EN adds sticky underrun/abort flags.
// Latency: rx_valid and state changes 3 i_clk cycles after the pad event.
// Backpressure: single-entry tx buffer (valid/ready); rx has none, new characters overwrite.
module spi_slave_shift #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 5
) (
    input logic               i_clk,
    input logic               i_rst,
    spi_slave_shift_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q;
    logic               sclk_s1_q, sclk_s2_q, sclk_h_q;
    logic               ss_s1_q, ss_s2_q, ss_h_q;
    logic               mosi_s1_q, mosi_s2_q;
    logic [1:0]         prime_q;
    logic               armed_q;
    logic [LEN_W-1:0]   len_q;
    logic               lsb_q, rxn_q, txn_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               sampled_q;
    logic [MAX_LEN-1:0] rx_shift_q, tx_shift_q, tx_buf_q, rx_data_q;
    logic               tx_full_q, rx_valid_q, busy_q;

    logic               sclk_rise, sclk_fall, ss_fall;
    logic               sample_edge, launch_edge, last_sample;
    logic               tx_accept, start;
    logic [IDX_W-1:0]   msb_idx;
    logic [MAX_LEN-1:0] rx_shift_d, tx_shift_d;
    logic               tx_bit;

    assign sclk_rise   = sclk_s2_q & ~sclk_h_q;
    assign sclk_fall   = ~sclk_s2_q & sclk_h_q;
    assign ss_fall     = ~ss_s2_q & ss_h_q;
    assign sample_edge = rxn_q ? sclk_fall : sclk_rise;
    // The first tx bit is held until a sample has been taken, whatever the mode.
    assign launch_edge = (txn_q ? sclk_fall : sclk_rise) & sampled_q;
    assign msb_idx     = (len_q == '0) ? IDX_W'(MAX_LEN - 1) : IDX_W'(len_q - 1'b1);
    assign last_sample = sample_edge && (bit_cnt_q == CNT_W'(msb_idx));
    assign tx_accept   = bus.i_tx_valid & ~tx_full_q;
    assign start       = ((state_q == IDLE) & ss_fall & armed_q)
                       | ((state_q == SHIFT) & ~ss_s2_q & last_sample);
    assign tx_bit      = lsb_q ? tx_shift_q[0] : tx_shift_q[msb_idx];

    always_comb begin
        rx_shift_d = '0;
        tx_shift_d = '0;
        if (lsb_q) begin
            rx_shift_d          = rx_shift_q >> 1;
            rx_shift_d[msb_idx] = mosi_s2_q;
            tx_shift_d          = tx_shift_q >> 1;
        end else begin
            rx_shift_d = {rx_shift_q[MAX_LEN-2:0], mosi_s2_q};
            tx_shift_d = tx_shift_q << 1;
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic underrun_q, abort_q;
    assign bus.o_underrun = underrun_q;
    assign bus.o_abort    = abort_q;
`else
    // Underruns and aborts are silent in this build.
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            sclk_s1_q  <= 1'b0;
            sclk_s2_q  <= 1'b0;
            sclk_h_q   <= 1'b0;
            ss_s1_q    <= 1'b1;
            ss_s2_q    <= 1'b1;
            ss_h_q     <= 1'b1;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            prime_q    <= '0;
            armed_q    <= 1'b0;
            len_q      <= '0;
            lsb_q      <= 1'b0;
            rxn_q      <= 1'b0;
            txn_q      <= 1'b0;
            bit_cnt_q  <= '0;
            sampled_q  <= 1'b0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            rx_data_q  <= '0;
            tx_full_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SPI_SLAVE_STATUS_EN
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
`endif
        end else begin
            sclk_s1_q <= bus.i_pad_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_h_q  <= sclk_s2_q;
            ss_s1_q   <= bus.i_pad_ss;
            ss_s2_q   <= ss_s1_q;
            ss_h_q    <= ss_s2_q;
            mosi_s1_q <= bus.i_pad_mosi;
            mosi_s2_q <= mosi_s1_q;
            // Synced ss only counts once it holds a real pad sample, not its reset value.
            prime_q   <= {prime_q[0], 1'b1};
            if (ss_s2_q && prime_q[1]) armed_q <= 1'b1;

            rx_valid_q <= 1'b0;
            tx_full_q  <= (tx_full_q & ~start) | tx_accept;
            if (tx_accept) tx_buf_q <= bus.i_tx_data;

            if (state_q == SHIFT) begin
                if (ss_s2_q) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_q <= rx_shift_d;
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                        sampled_q  <= 1'b1;
                        if (last_sample) begin
                            rx_data_q  <= rx_shift_d;
                            rx_valid_q <= 1'b1;
                        end
                    end
                    if (launch_edge) begin
                        tx_shift_q <= tx_shift_d;
                        if (!sample_edge) sampled_q <= 1'b0;
                    end
                end
            end

            if (start) begin
                state_q    <= SHIFT;
                busy_q     <= 1'b1;
                len_q      <= bus.i_len;
                lsb_q      <= bus.i_lsb;
                rxn_q      <= bus.i_rx_negedge;
                txn_q      <= bus.i_tx_negedge;
                bit_cnt_q  <= '0;
                sampled_q  <= 1'b0;
                rx_shift_q <= '0;
                tx_shift_q <= tx_full_q ? tx_buf_q : '0;
            end

`ifdef SPI_SLAVE_STATUS_EN
            underrun_q <= (start & ~tx_full_q) | (underrun_q & ~bus.i_status_clr);
            abort_q    <= ((state_q == SHIFT) & ss_s2_q) | (abort_q & ~bus.i_status_clr);
`endif
        end
    end

    assign bus.o_tx_ready    = ~tx_full_q;
    assign bus.o_rx_data     = rx_data_q;
    assign bus.o_rx_valid    = rx_valid_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_pad_miso_oe = (state_q == SHIFT) & ~ss_s2_q;
    assign bus.o_pad_miso    = bus.o_pad_miso_oe & tx_bit;
endmodule

// File: doc/spi_slave_shift.md
Name: spi_slave_shift

Overview:
- SPI responder (slave) for the far end of the team's SPI master link.
- Receives MOSI and drives MISO under an external master's SCLK/SS.
- Exposes a parallel tx-load / rx-deliver interface to local logic.
- All pad inputs are oversampled in the single i_clk domain; no logic is clocked by SCLK.
- Mode controls (char length, LSB-first, rx/tx edge select) match the master's control-register fields, so both ends are configured identically.

Parameters:
- MAX_LEN, 32, maximum character length in bits; also the width of the tx/rx data ports.
- LEN_W, 5, width of i_len. i_len==0 means MAX_LEN bits.

Ports:
- i_clk  in  1  system clock; must be at least 4x the SCLK frequency.
- i_rst  in  1  synchronous, active-high reset.
- i_len  in  LEN_W  character length.
- i_lsb  in  1  1 = bit 0 first, 0 = MSB (bit len-1) first.
- i_rx_negedge  in  1  1 = sample MOSI on SCLK falling edge, 0 = on rising edge.
- i_tx_negedge  in  1  1 = launch MISO on SCLK falling edge, 0 = on rising edge.
- i_tx_data  in  MAX_LEN  next tx character, right-aligned.
- i_tx_valid  in  1  tx load request.
- o_tx_ready  out  1  single-entry tx buffer is empty.
- o_rx_data  out  MAX_LEN  last received character, right-aligned, upper bits 0.
- o_rx_valid  out  1  one-cycle pulse when o_rx_data updates.
- o_busy  out  1  character in progress.
- i_pad_sclk  in  1  SPI clock from master.
- i_pad_ss  in  1  slave select, active low.
- i_pad_mosi  in  1  serial data in.
- o_pad_miso  out  1  serial data out.
- o_pad_miso_oe  out  1  MISO output enable.

Behaviour:
- Synchronizers: 2-flop sync on sclk/ss/mosi, plus one history flop on sclk and ss for edge detect.
  - Synchronizer reset values: ss=1, sclk=0.
  - rx_valid and state changes follow a pad event by 3 i_clk cycles.
- Reset values: o_tx_ready=1, o_rx_valid=0, o_rx_data=0, o_busy=0, o_pad_miso=0, o_pad_miso_oe=0; FSM=IDLE; armed=0.
- Armed flag: set whenever synced ss is high. A start requires armed=1, so a reset released while SS is already low causes no start until SS goes high then low again.
- FSM IDLE: on synced ss falling with armed=1, go to SHIFT and perform a char start.
- Char start:
  - Latch i_len, i_lsb, i_rx_negedge and i_tx_negedge; later changes to these inputs are ignored until the next char start.
  - bit_cnt=0.
  - tx shift register loads the buffer contents if the buffer is full (buffer freed, so o_tx_ready=1 next cycle); otherwise it loads zeros (underrun).
  - First tx bit (bit 0 if lsb, else bit len-1) appears on o_pad_miso the next cycle.
  - o_busy=1.
- SHIFT:
  - Sample edge: shift synced mosi into rx_shift and increment bit_cnt.
  - Launch edge: advance to the next tx bit, only if at least one sample has occurred since the last launch. This means the first tx bit is held until after the first sample, in every mode.
  - When bit_cnt reaches len after a sample: next cycle o_rx_data gets the received bits (LSB-first characters bit-reversed into place, right-aligned) and o_rx_valid=1 for exactly one cycle.
  - Then, if synced ss is still low, perform an immediate char start (back-to-back characters); otherwise go to IDLE.
- SS rises mid-character: abort to IDLE next cycle. o_busy=0, no rx_valid, partial data discarded, o_rx_data unchanged. The consumed tx word is lost.
- o_pad_miso_oe = synced ss low while in SHIFT. o_pad_miso is 0 whenever oe=0.
- tx buffer:
  - A load is accepted when i_tx_valid && o_tx_ready, and o_tx_ready drops the next cycle.
  - i_tx_valid while not ready is ignored (no overwrite).
  - A load accepted in the same cycle as a char start that found the buffer empty fills the buffer for the following character.
- o_rx_valid has no backpressure: a new character overwrites o_rx_data.
- Reset asserted mid-transfer: everything returns to reset values at the next i_clk edge.

Optional Feature:
- SPI_SLAVE_STATUS_EN defined:
  - Adds input i_status_clr and outputs o_underrun and o_abort (sticky, reset 0).
  - o_underrun sets on a char start that found the tx buffer empty.
  - o_abort sets on SS rising mid-character.
  - Both clear on i_status_clr. If set and clear occur in the same cycle, set wins.
- Undefined: these ports and their logic are absent; underruns and aborts are silent.

Test Plan:
- len=8, lsb=0, rx_negedge=0, tx_negedge=1; load 0xA5; master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; o_rx_data=0x0000003C; single o_rx_valid pulse; o_tx_ready=1 after start.
- len=0 (32 bits), lsb=1; load 0x12345678; master sends 0xDEADBEEF LSB-first -> o_rx_data=0xDEADBEEF; master captures 0x12345678.
- Two back-to-back 8-bit characters with SS held low; buffer reloaded with 0x81 during the first -> second MISO byte is 0x81; two rx_valid pulses.
- No tx load before start -> MISO all zeros; with SPI_SLAVE_STATUS_EN, o_underrun=1 until i_status_clr.
- SS rises after 5 of 8 bits -> no rx_valid; o_rx_data holds its previous value; o_busy=0 within 4 cycles; o_abort=1 if the macro is defined.
- Assert i_rst with SS low mid-character, release while SS still low -> no activity until SS toggles high then low; the next character is received correctly.
